// File: rtl/prog_clk_div_if.sv
// Control/status bundle for prog_clk_div.
// master: the side that drives enable and ratio loads (system or bench).
// slave:  the divider itself.
interface prog_clk_div_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 i_en;
  logic [CNT_WIDTH-1:0] i_div_ratio;
  logic                 i_div_load;
  logic                 o_div_clk;
  logic                 o_div_pulse;
  logic                 o_load_ack;
  logic [CNT_WIDTH-1:0] o_ratio_active;

  modport master (
    output i_en, i_div_ratio, i_div_load,
    input  o_div_clk, o_div_pulse, o_load_ack, o_ratio_active
  );

  modport slave (
    input  i_en, i_div_ratio, i_div_load,
    output o_div_clk, o_div_pulse, o_load_ack, o_ratio_active
  );
endinterface

// File: rtl/prog_clk_div.sv
// prog_clk_div: runtime-programmable integer clock divider.
// A new ratio is held pending and only swapped in on a period boundary,
// so the divided clock never produces a runt pulse. Disabling the block
// freezes the count and stretches the current period.
// Optional feature: define ODD_DUTY50_EN to add a falling-edge flop that
// extends the high phase by half a cycle for odd ratios (exact 50% duty).
module prog_clk_div #(
  parameter int CNT_WIDTH   = 8,
  parameter int DEFAULT_DIV = 6
) (
  input  logic          i_clk,
  input  logic          i_reset,
  prog_clk_div_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] DIV_RST = CNT_WIDTH'(DEFAULT_DIV);
  // Start one short of the wrap so the first enabled edge opens a period.
  localparam logic [CNT_WIDTH-1:0] CNT_RST = CNT_WIDTH'(DEFAULT_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] MIN_DIV = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_p0;
  logic [CNT_WIDTH-1:0] n_act_p0;
  logic [CNT_WIDTH-1:0] pend_val_p0;
  logic                 pend_vld_p0;
  logic                 div_a_p0;
  logic                 pulse_p0;
  logic                 ack_p0;

  logic                 boundary;
  logic                 apply;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [CNT_WIDTH-1:0] n_next;
  logic                 div_a_next;

  // Ratios below 2 cannot form a period with both a high and a low phase.
  function automatic logic [CNT_WIDTH-1:0] clamp_ratio(input logic [CNT_WIDTH-1:0] r);
    return (r < MIN_DIV) ? MIN_DIV : r;
  endfunction

  // Wrap detection, pending-ratio swap and the next level of the divided clock.
  always_comb begin
    boundary   = (cnt_p0 == (n_act_p0 - ONE));
    apply      = boundary && pend_vld_p0;
    cnt_next   = boundary ? '0 : (cnt_p0 + ONE);
    n_next     = apply ? pend_val_p0 : n_act_p0;
    div_a_next = (cnt_next < (n_next >> 1));
  end

  // ---- stage p0: counter, active ratio, pending load and output strobes ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_p0      <= CNT_RST;
      n_act_p0    <= DIV_RST;
      pend_val_p0 <= '0;
      pend_vld_p0 <= 1'b0;
      div_a_p0    <= 1'b0;
      pulse_p0    <= 1'b0;
      ack_p0      <= 1'b0;
    end else begin
      if (bus.i_en) begin
        cnt_p0   <= cnt_next;
        n_act_p0 <= n_next;
        div_a_p0 <= div_a_next;
        pulse_p0 <= boundary;
        ack_p0   <= apply;
      end else begin
        pulse_p0 <= 1'b0;
        ack_p0   <= 1'b0;
      end
      // A load on the apply edge replaces the value being consumed, so the
      // new request stays pending for the following boundary.
      if (bus.i_div_load) begin
        pend_val_p0 <= clamp_ratio(bus.i_div_ratio);
        pend_vld_p0 <= 1'b1;
      end else if (bus.i_en && apply) begin
        pend_vld_p0 <= 1'b0;
      end
    end
  end

`ifdef ODD_DUTY50_EN
  logic div_b_p0;

  // Half-cycle-late copy of the divided clock, only kept for odd ratios.
  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      div_b_p0 <= 1'b0;
    end else begin
      div_b_p0 <= div_a_p0 & n_act_p0[0];
    end
  end

  assign bus.o_div_clk = div_a_p0 | div_b_p0;
`else
  assign bus.o_div_clk = div_a_p0;
`endif

  assign bus.o_div_pulse    = pulse_p0;
  assign bus.o_load_ack     = ack_p0;
  assign bus.o_ratio_active = n_act_p0;

endmodule

// File: tb/tb_prog_clk_div.sv
// Testbench for prog_clk_div: a period-level reference model checked every
// cycle on the 8-bit instance, plus directed waveform patterns on both the
// 8-bit and a 5-bit instance (maximum ratio 31).
module tb_prog_clk_div;

  localparam int W   = 8;
  localparam int W2  = 5;
  localparam int DEF = 6;

  logic clk;
  logic rst;
  logic rst2;

  int n_cmp = 0;
  int n_bad = 0;

  prog_clk_div_if #(.CNT_WIDTH(W))  bus ();
  prog_clk_div_if #(.CNT_WIDTH(W2)) bus2 ();

  prog_clk_div #(.CNT_WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  prog_clk_div #(.CNT_WIDTH(W2), .DEFAULT_DIV(DEF)) dut2 (
    .i_clk   (clk),
    .i_reset (rst2),
    .bus     (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks position within the current output period (0 = first cycle) and
  // the ratio governing it; the clock is high for the first N/2 enabled
  // cycles of every period.
  int m_n, m_pos, m_pend_val;
  bit m_pend, m_a, m_b, m_pulse, m_ack;

  task automatic model_step();
    bit period_done;
    if (rst) begin
      m_n = DEF; m_pos = DEF - 1; m_pend = 0; m_pend_val = 0;
      m_a = 0; m_b = 0; m_pulse = 0; m_ack = 0;
    end else begin
      // half-cycle-late copy as seen just after this edge: previous level, odd ratios only
      m_b = m_a && (m_n % 2 == 1);
      period_done = bus.i_en && (m_pos == m_n - 1);
      m_pulse = 0;
      m_ack = 0;
      if (bus.i_en) begin
        if (period_done) begin
          m_pos = 0;
          m_pulse = 1;
          if (m_pend) begin
            m_n = m_pend_val;
            m_pend = 0;
            m_ack = 1;
          end
        end else begin
          m_pos = m_pos + 1;
        end
        m_a = (m_pos < m_n / 2);
      end
      if (bus.i_div_load) begin
        m_pend_val = (int'(bus.i_div_ratio) < 2) ? 2 : int'(bus.i_div_ratio);
        m_pend = 1;
      end
    end
  endtask

  initial begin
    bit exp_clk;
    forever begin
      @(posedge clk);
      model_step();
      #1;
`ifdef ODD_DUTY50_EN
      exp_clk = m_a | m_b;
`else
      exp_clk = m_a;
`endif
      chk("model_clk",   32'(bus.o_div_clk),      32'(exp_clk));
      chk("model_pulse", 32'(bus.o_div_pulse),    32'(m_pulse));
      chk("model_ack",   32'(bus.o_load_ack),     32'(m_ack));
      chk("model_ratio", 32'(bus.o_ratio_active), 32'(m_n));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0:       return bus.o_load_ack;
      1:       return bus.o_div_pulse;
      default: return bus2.o_load_ack;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel, input int bound, output int cyc);
    cyc = 0;
    while (!sig(sel) && cyc < bound) begin
      tick();
      cyc++;
    end
    chk(name, 32'(sig(sel)), 32'd1);
  endtask

  task automatic capture(input bit second, input int n, output int cp, output int pp, output int ac);
    cp = 0; pp = 0; ac = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (second) begin
        cp = (cp << 1) | int'(bus2.o_div_clk);
        pp = (pp << 1) | int'(bus2.o_div_pulse);
        ac = ac + int'(bus2.o_load_ack);
      end else begin
        cp = (cp << 1) | int'(bus.o_div_clk);
        pp = (pp << 1) | int'(bus.o_div_pulse);
        ac = ac + int'(bus.o_load_ack);
      end
    end
  endtask

  task automatic load(input int v);
    bus.i_div_ratio = W'(v);
    bus.i_div_load  = 1'b1;
    tick();
    bus.i_div_load  = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cp, pp, ac, cyc, c0;
    rst = 1'b1; rst2 = 1'b1;
    bus.i_en = 1'b0;  bus.i_div_ratio = '0;  bus.i_div_load = 1'b0;
    bus2.i_en = 1'b0; bus2.i_div_ratio = '0; bus2.i_div_load = 1'b0;
    tick(); tick();
    chk("rst_clk",   32'(bus.o_div_clk), 0);
    chk("rst_pulse", 32'(bus.o_div_pulse), 0);
    chk("rst_ack",   32'(bus.o_load_ack), 0);
    chk("rst_ratio", 32'(bus.o_ratio_active), 6);

    // Default ratio 6: 3 high / 3 low, pulse on the first cycle of each period
    rst = 1'b0; bus.i_en = 1'b1;
    capture(0, 12, cp, pp, ac);
    chk("dflt_clk_pat",   32'(cp), 'b111000111000);
    chk("dflt_pulse_pat", 32'(pp), 'b100000100000);

    // Load 5 while at position 2: current period completes first
    tick();
    chk("p3_pulse", 32'(bus.o_div_pulse), 1);
    tick(); tick();
    load(5);
    wait_for("ack5_seen", 0, 10, cyc);
    chk("ack5_latency", 32'(cyc), 3);
    chk("ack5_pulse",   32'(bus.o_div_pulse), 1);
    chk("ratio5",       32'(bus.o_ratio_active), 5);
    c0 = int'(bus.o_div_clk);
    capture(0, 9, cp, pp, ac);
`ifdef ODD_DUTY50_EN
    chk("n5_clk_pat", 32'((c0 << 9) | cp), 'b1110011100);
`else
    chk("n5_clk_pat", 32'((c0 << 9) | cp), 'b1100011000);
`endif

    // Clamp: load 0 on a boundary edge with nothing pending -> applied next boundary
    load(0);
    chk("clamp0_not_yet", 32'(bus.o_load_ack), 0);
    wait_for("ack_clamp0_seen", 0, 10, cyc);
    chk("clamp0_latency", 32'(cyc), 5);
    chk("clamp0_ratio",   32'(bus.o_ratio_active), 2);
    c0 = int'(bus.o_div_clk);
    capture(0, 5, cp, pp, ac);
    chk("clamp0_clk_pat", 32'((c0 << 5) | cp), 'b101010);

    load(1);
    wait_for("ack_clamp1_seen", 0, 10, cyc);
    chk("clamp1_ratio", 32'(bus.o_ratio_active), 2);
    c0 = int'(bus.o_div_clk);
    capture(0, 5, cp, pp, ac);
    chk("clamp1_clk_pat", 32'((c0 << 5) | cp), 'b101010);

    // Last wins: back to 6, then load 4 and 9 within one period
    load(6);
    wait_for("ack6_seen", 0, 10, cyc);
    chk("ratio6", 32'(bus.o_ratio_active), 6);
    load(4);
    tick();
    load(9);
    wait_for("ack9_seen", 0, 10, cyc);
    chk("ratio9", 32'(bus.o_ratio_active), 9);
    c0 = int'(bus.o_div_clk);
    capture(0, 8, cp, pp, ac);
`ifdef ODD_DUTY50_EN
    chk("n9_clk_pat", 32'((c0 << 8) | cp), 'b111110000);
`else
    chk("n9_clk_pat", 32'((c0 << 8) | cp), 'b111100000);
`endif
    capture(0, 18, cp, pp, ac);
    chk("n9_no_second_ack", 32'(ac), 0);
    chk("n9_two_pulses",    32'($countones(pp)), 2);

    // Enable gap of 4 cycles inside the high phase of a 6-cycle period
    load(6);
    wait_for("ack6b_seen", 0, 12, cyc);
    cp = 0; pp = 0;
    for (int i = 1; i <= 10; i++) begin
      bus.i_en = (i < 2 || i > 5);
      tick();
      cp = (cp << 1) | int'(bus.o_div_clk);
      pp = (pp << 1) | int'(bus.o_div_pulse);
    end
    chk("gap_clk_pat",   32'(cp), 'b1111110001);
    chk("gap_pulse_pat", 32'(pp), 'b0000000001);

    // Reset at position 3 with 12 pending: load discarded, restart at 6
    load(12);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_clk",   32'(bus.o_div_clk), 0);
    chk("mid_rst_pulse", 32'(bus.o_div_pulse), 0);
    chk("mid_rst_ack",   32'(bus.o_load_ack), 0);
    chk("mid_rst_ratio", 32'(bus.o_ratio_active), 6);
    capture(0, 12, cp, pp, ac);
    chk("restart_clk_pat",   32'(cp), 'b111000111000);
    chk("restart_pulse_pat", 32'(pp), 'b100000100000);
    chk("restart_no_ack",    32'(ac), 0);
    chk("restart_ratio",     32'(bus.o_ratio_active), 6);

    // 5-bit instance, maximum ratio 31
    rst2 = 1'b0;
    bus2.i_en = 1'b1;
    bus2.i_div_ratio = W2'(31);
    bus2.i_div_load = 1'b1;
    tick();
    bus2.i_div_load = 1'b0;
    wait_for("ack31_seen", 2, 20, cyc);
    chk("ack31_latency", 32'(cyc), 6);
    chk("ratio31",       32'(bus2.o_ratio_active), 31);
    c0 = int'(bus2.o_div_clk);
    capture(1, 30, cp, pp, ac);
`ifdef ODD_DUTY50_EN
    chk("n31_clk_pat", 32'((c0 << 30) | cp), 32'h7FFF8000);
`else
    chk("n31_clk_pat", 32'((c0 << 30) | cp), 32'h7FFF0000);
`endif
    chk("n31_no_midpulse", 32'(pp), 0);
    tick();
    chk("n31_wrap_pulse", 32'(bus2.o_div_pulse), 1);
    chk("n31_wrap_clk",   32'(bus2.o_div_clk), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_clk_div.md
Name: prog_clk_div

Overview:
Runtime-programmable integer clock divider. It generalises the fixed-ratio divider blocks with a parameterised counter width and a divide ratio that can be reloaded while running. Ratio changes take effect only at a period boundary, so the divided output never glitches. It also has an enable, a period-start strobe and a load acknowledge. It sits between the system clock and low-rate peripheral timing logic.

Parameters:
CNT_WIDTH, 8, width of counter, ratio input and active-ratio output; max ratio 2^CNT_WIDTH-1
DEFAULT_DIV, 6, divide ratio after reset; legal range 2..2^CNT_WIDTH-1

Ports:
i_clk  input  1  system clock, all logic on rising edge (optional feature also uses falling edge)
i_reset  input  1  synchronous reset, active-high
i_en  input  1  count enable; low freezes the divider
i_div_ratio  input  CNT_WIDTH  requested divide ratio N
i_div_load  input  1  one-cycle request to capture i_div_ratio
o_div_clk  output  1  divided clock, registered
o_div_pulse  output  1  one-cycle strobe in the first cycle of each output period
o_load_ack  output  1  one-cycle strobe: pending ratio has just been applied
o_ratio_active  output  CNT_WIDTH  ratio currently in use

Behaviour:
- Reset (single clock; synchronous, active-high reset):
  - cnt = DEFAULT_DIV-1, active N = DEFAULT_DIV, pending register = 0, pending flag = 0.
  - Outputs: o_div_clk=0, o_div_pulse=0, o_load_ack=0, o_ratio_active=DEFAULT_DIV.
- Counter: on each edge with i_en=1, cnt increments; at cnt==N-1 it wraps to 0 (the "boundary edge").
- Output waveform: on the same edge, o_div_clk <= (cnt_next < N>>1).
  - High for floor(N/2) enabled cycles, then low for N-floor(N/2).
  - Even N gives exactly 50% duty.
- First period: the first enabled edge after reset release wraps cnt to 0, so o_div_clk rises and o_div_pulse asserts one edge after reset deasserts.
- o_div_pulse: high exactly in cycles where cnt==0 following a boundary edge; 0 when i_en=0.
- Load capture: i_div_load=1 captures i_div_ratio into the pending register and sets the pending flag.
  - Values 0 and 1 are clamped to 2 at capture.
  - A second load before the boundary overwrites the pending value (last wins); only one ack is generated.
- Apply: on a boundary edge with the pending flag already set before that cycle:
  - active N <= pending value, o_ratio_active updated, pending flag cleared.
  - o_load_ack=1 for the following cycle (coincident with o_div_pulse).
  - The new N governs o_div_clk from that edge onward.
- Load on a boundary cycle:
  - If no pending value exists, the load is applied at the next boundary.
  - If a pending value exists, the old pending value is applied now and the new one stays pending.
- i_en=0: cnt, o_div_clk and the active ratio hold; o_div_pulse and o_load_ack are 0; loads are still captured. The period stretches by the number of disabled cycles.
- Reset mid-operation: all state returns to reset values on that edge; pending loads are discarded.

Optional Feature:
Macro ODD_DUTY50_EN.
- Defined: adds a falling-edge flop b that copies posedge output a half a cycle late, also synchronously cleared by i_reset on the falling edge.
  - For odd N, o_div_clk = a | b, giving high time N/2 cycles (exact 50% duty).
  - For even N, o_div_clk = a.
  - o_div_clk then goes through one OR gate after the flops; it is the only non-registered output.
- Undefined: no falling-edge logic; odd N gives floor(N/2) high, ceil(N/2) low.

Test Plan:
- Default period: DEFAULT_DIV=6, CNT_WIDTH=8, reset 2 cycles then i_en=1 -> o_div_clk rises 1 edge after reset release, then 3 high / 3 low repeating; o_div_pulse every 6 cycles; o_ratio_active=6.
- Mid-period load of 5 at cnt==2 -> the current 6-cycle period completes, then o_load_ack and o_div_pulse together; o_ratio_active=5.
  - Macro off: 2 high / 3 low.
  - Macro on: 2.5 high / 2.5 low.
- Clamp: load 0 -> after boundary o_ratio_active=2, o_div_clk toggles every cycle; repeat with load 1, same result.
- Last-wins: load 4 then load 9 in the same period -> a single o_load_ack at the boundary, o_ratio_active=9, 4 high / 5 low (macro off).
- Enable gap: drop i_en for 4 cycles during the high phase with N=6 -> o_div_clk held high, that high phase lasts 7 cycles, no pulses during the gap, next pulse 10 cycles after the previous one.
- Reset mid-run: pending load of 12 outstanding, assert i_reset 1 cycle at cnt==3 -> all outputs return to reset values, the load is never acked, and operation restarts with N=6.
- Max ratio: CNT_WIDTH=5, load 31 -> 15 high / 16 low, cnt wraps correctly with no overflow.
